// File: rtl/minimips_alu_pkg.sv
// Shared definitions for the MiniMIPS execute stage: opcodes, FSM encoding,
// multiplier step count and the single-cycle ALU function.
package minimips_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;

  localparam int MULT_STEPS = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // MULT and the illegal opcodes fall through to zero here.
  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'b0, a < b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // 32'h8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_ex_stage_mult.sv
// Sequential shift-add multiplier engine (mult_seq_32), one step per cycle.
// Only compiled and used when ALU_MULT_EN is defined.
`ifdef ALU_MULT_EN
module mult_seq_32
  import minimips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
  input  logic        sign,
  output logic        done,
  output logic [63:0] product
);

  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic        neg;

  // Counter parks at MULT_STEPS when idle so no stray steps run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= 6'(MULT_STEPS);
      neg    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {32'b0, mag_a};
      mplier <= mag_b;
      cnt    <= '0;
      neg    <= sign;
    end else if (cnt != 6'(MULT_STEPS)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
    end
  end

  assign done    = (cnt == 6'(MULT_STEPS));
  assign product = neg ? -acc : acc;

endmodule
`endif

// File: rtl/alu_ex_stage.sv
// MiniMIPS registered execute stage with valid/ready handshake on both sides.
// Define ALU_MULT_EN to add the multi-cycle signed MULT (hi/result) path.
module alu_ex_stage
  import minimips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             busy
);

  logic accept;
  logic drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

`ifdef ALU_MULT_EN
  state_t      state, state_nx;
  logic        mul_start;
  logic        mul_done;
  logic        mul_load;
  logic [63:0] product;

  // A finished product waits in MUL until the output register is free.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mul_start = 1'b0;
    mul_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && op == OP_MULT) begin
          mul_start = 1'b1;
          state_nx  = ST_MUL;
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (mul_done && (!out_valid || out_ready)) begin
          mul_load = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  mult_seq_32 u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .mag_a   (magnitude(a)),
    .mag_b   (magnitude(b)),
    .sign    (a[WIDTH-1] ^ b[WIDTH-1]),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
    end else begin
      state <= state_nx;
      if (mul_load) begin
        result    <= product[31:0];
        hi        <= product[63:32];
        out_valid <= 1'b1;
      end else if (accept && op != OP_MULT) begin
        result    <= alu_calc(op, a, b);
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;
  assign hi       = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      result    <= alu_calc(op, a, b);
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage; follows ALU_MULT_EN like the design.
module tb_alu_ex_stage;
  import minimips_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_hi;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_p;
  logic [31:0] held;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .busy      (busy)
  );

  // Reference model: the opcode table expressed as plain arithmetic.
  function automatic logic [31:0] refAlu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ~(x | y);
      4'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] refMult(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic rdy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic runSingle(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    applyStimulus(1'b1, o, x, y, 1'b1);
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " result"}, 64'(result), 64'(refAlu(o, x, y)));
    checkOutput({tag, " hi"}, 64'(hi), 64'(exp_hi));
    waitCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    exp_hi = 32'd0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    waitCycle();
    waitCycle();
    rst_n = 1'b1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);

    runSingle("slt neg", OP_SLT, 32'hFFF00000, 32'd0);
    checkOutput("slt neg const", 64'(result), 64'd1);
    runSingle("sltu big", OP_SLTU, 32'hFFF00000, 32'd0);
    runSingle("slt pos", OP_SLT, 32'h40000000, 32'h3FFFFFFF);
    runSingle("add wrap", OP_ADD, 32'h7FFFFFFF, 32'd1);
    checkOutput("add wrap const", 64'(result), 64'h80000000);
    runSingle("sub wrap", OP_SUB, 32'd0, 32'd1);
    runSingle("slt minint", OP_SLT, 32'h80000000, 32'h7FFFFFFF);
    runSingle("illegal op", 4'd12, 32'h12345678, 32'h9ABCDEF0);

`ifdef ALU_MULT_EN
    applyStimulus(1'b1, OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
    checkOutput("mult in_ready", 64'(in_ready), 64'd1);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    for (int j = 1; j <= 32; j++) begin
      waitCycle();
      checkOutput($sformatf("mult busy c%0d", j), 64'(busy), 64'd1);
      checkOutput($sformatf("mult in_ready c%0d", j), 64'(in_ready), 64'd0);
    end
    waitCycle();
    checkOutput("mult out_valid", 64'(out_valid), 64'd1);
    checkOutput("mult result", 64'(result), 64'hFFFFFFEB);
    checkOutput("mult hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("mult busy done", 64'(busy), 64'd0);
    exp_hi = 32'hFFFFFFFF;
    waitCycle();

    for (int k = 0; k < 4; k++) begin
      r_a = $urandom;
      r_b = $urandom;
      if (k == 0) r_a = 32'h80000000;
      r_p = refMult(r_a, r_b);
      applyStimulus(1'b1, OP_MULT, r_a, r_b, 1'b1);
      waitCycle();
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      for (int w = 0; w < 40 && !out_valid; w++) waitCycle();
      checkOutput($sformatf("rmult%0d out_valid", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("rmult%0d product", k), {hi, result}, r_p);
      exp_hi = r_p[63:32];
      waitCycle();
    end
`else
    runSingle("mult disabled", OP_MULT, 32'hFFFFFFFD, 32'd7);
    checkOutput("mult disabled busy", 64'(busy), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(15, 0));
`ifdef ALU_MULT_EN
      if (r_op == OP_MULT) r_op = OP_XOR;
`endif
      r_a = $urandom;
      r_b = (i % 5 == 0) ? r_a : $urandom;
      applyStimulus(1'b1, r_op, r_a, r_b, 1'b1);
      checkOutput($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
      waitCycle();
      checkOutput($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stream%0d result", i), 64'(result), 64'(refAlu(r_op, r_a, r_b)));
      checkOutput($sformatf("stream%0d busy", i), 64'(busy), 64'd0);
      checkOutput($sformatf("stream%0d hi", i), 64'(hi), 64'(exp_hi));
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    waitCycle();

    applyStimulus(1'b1, OP_ADD, 32'd100, 32'd23, 1'b0);
    checkOutput("bp first in_ready", 64'(in_ready), 64'd1);
    waitCycle();
    held = refAlu(OP_ADD, 32'd100, 32'd23);
    applyStimulus(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd5, 1'b0);
    checkOutput("bp second blocked", 64'(in_ready), 64'd0);
    for (int s = 0; s < 3; s++) begin
      waitCycle();
      checkOutput($sformatf("bp hold%0d result", s), 64'(result), 64'(held));
      checkOutput($sformatf("bp hold%0d out_valid", s), 64'(out_valid), 64'd1);
    end
    applyStimulus(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd5, 1'b1);
    checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("bp second result", 64'(result), 64'(refAlu(OP_ADD, 32'hFFFFFFFF, 32'd5)));
    checkOutput("bp second out_valid", 64'(out_valid), 64'd1);
    waitCycle();
    checkOutput("bp drained", 64'(out_valid), 64'd0);

`ifdef ALU_MULT_EN
    applyStimulus(1'b1, OP_MULT, 32'h00012345, 32'hFFFF0003, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    repeat (9) waitCycle();
    checkOutput("abort busy before", 64'(busy), 64'd1);
`else
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd6, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("abort held before", 64'(out_valid), 64'd1);
`endif
    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    exp_hi = 32'd0;
    checkOutput("abort out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort result", 64'(result), 64'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    for (int q = 0; q < 40; q++) begin
      waitCycle();
      checkOutput($sformatf("abort quiet%0d", q), 64'(out_valid), 64'd0);
      if (out_valid) break;
    end
    runSingle("post-reset add", OP_ADD, 32'd2, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
